// File: rtl/load_store_unit.sv
// Load/store unit: runs one decoded load or store against a 32-bit word bus with byte enables.
// Latency: accept at t, first beat at t+1, done at t+2 when aligned with zero-wait ack; each wait state
//          adds a cycle; an access that crosses a word boundary adds a second beat.
// Backpressure: beats are held stable until mem_ack; busy stays high until done and req_valid is
//               ignored while busy.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   req_valid, data_r, data_w,      request strobe and decoded memory controls,
//   data_size, unsigned_value,      latched on accept
//   addr, wdata
//   busy, done, fault, rdata        status pulses and the sign/zero-extended load result
//   mem_req, mem_we, mem_addr,      word-addressed bus beat (lane-steered write data)
//   mem_be, mem_wdata
//   mem_rdata, mem_ack              bus response; read data valid in the ack cycle
module load_store_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        data_r,
    input  logic        data_w,
    input  logic [1:0]  data_size,
    input  logic        unsigned_value,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Request-side lane math, evaluated on the raw inputs so it can be latched at accept.
    logic [3:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [63:0] wide_w;
    logic        req_split;
    logic        req_seen;
    logic        req_bad;
    logic        accept;

    always_comb begin
        case (data_size)
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    assign lane_mask = {4'b0000, size_mask} << addr[1:0];
    assign wide_w    = {32'b0, wdata} << {addr[1:0], 3'b000};
    assign req_split = |lane_mask[7:4];
    // data_r=data_w=0 is not a request at all; both set is a request that faults.
    assign req_seen  = (state_q == S_IDLE) && req_valid && (data_r || data_w);
    assign req_bad   = (data_r && data_w) || (data_size == 2'b11) ||
                       (req_split && !ALLOW_MISALIGNED);
    assign accept    = req_seen && !req_bad;

    // Latched request
    logic [1:0]  off_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        we_q;
    logic        split_q;
    logic [3:0]  be1_q;
    logic [31:0] whi_q;
    logic [31:0] mem_addr_q;
    logic [3:0]  mem_be_q;
    logic [31:0] mem_wdata_q;
    logic [63:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q;
    logic        fault_q;

    // FSM: next state and control outputs
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        mem_req = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_BEAT0;
            end
            S_BEAT0: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) state_d = split_q ? S_BEAT1 : S_FIN;
            end
            S_BEAT1: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ack) state_d = S_FIN;
            end
            S_FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Read assembly: the ack-cycle data is merged in combinationally so the final
    // result can be registered on the same edge that enters FIN.
    logic [31:0] rsh;
    logic [31:0] load_val;
    logic        fin_entry;

    always_comb begin
        rbuf_d = rbuf_q;
        if (mem_ack && state_q == S_BEAT0) rbuf_d[31:0]  = mem_rdata;
        if (mem_ack && state_q == S_BEAT1) rbuf_d[63:32] = mem_rdata;
    end

    assign rsh = 32'(rbuf_d >> {off_q, 3'b000});

    always_comb begin
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, rsh[7:0]}   : {{24{rsh[7]}}, rsh[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, rsh[15:0]}  : {{16{rsh[15]}}, rsh[15:0]};
            default: load_val = rsh;
        endcase
    end

    assign fin_entry = (state_d == S_FIN) && (state_q != S_FIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            off_q       <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            we_q        <= 1'b0;
            split_q     <= 1'b0;
            be1_q       <= 4'b0000;
            whi_q       <= 32'b0;
            mem_addr_q  <= 32'b0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'b0;
            rbuf_q      <= 64'b0;
            rdata_q     <= 32'b0;
            fault_q     <= 1'b0;
        end else begin
            fault_q <= req_seen && req_bad;
            rbuf_q  <= rbuf_d;
            if (accept) begin
                off_q       <= addr[1:0];
                size_q      <= data_size;
                uns_q       <= unsigned_value;
                we_q        <= data_w;
                split_q     <= req_split;
                be1_q       <= lane_mask[7:4];
                whi_q       <= wide_w[63:32];
                mem_addr_q  <= {addr[31:2], 2'b00};
                mem_be_q    <= lane_mask[3:0];
                mem_wdata_q <= wide_w[31:0];
            end
            // Second beat goes out the cycle after the first ack; address wraps mod 2^32.
            if (state_q == S_BEAT0 && mem_ack && split_q) begin
                mem_addr_q  <= mem_addr_q + 32'd4;
                mem_be_q    <= be1_q;
                mem_wdata_q <= whi_q;
            end
            if (fin_entry && !we_q) rdata_q <= load_val;
        end
    end

    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        data_r = 1'b0;
    logic        data_w = 1'b0;
    logic [1:0]  data_size = 2'b00;
    logic        unsigned_value = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    logic        busy, done, fault, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    logic        d0_busy, d0_done, d0_fault, d0_mem_req, d0_mem_we;
    logic [31:0] d0_rdata, d0_mem_addr, d0_mem_wdata;
    logic [3:0]  d0_mem_be;

    load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .data_r(data_r), .data_w(data_w),
        .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .fault(fault), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .data_r(data_r), .data_w(data_w),
        .data_size(data_size), .unsigned_value(unsigned_value), .addr(addr), .wdata(wdata),
        .busy(d0_busy), .done(d0_done), .fault(d0_fault), .rdata(d0_rdata),
        .mem_req(d0_mem_req), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_be(d0_mem_be),
        .mem_wdata(d0_mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Bus RAM with configurable wait states, plus a log of every completed beat.
    logic [31:0] ram [256];
    int          waits_cfg = 0;
    int          cyc = 0;
    int          done_cnt = 0, fault_cnt = 0, d0_fault_cnt = 0, d0_req_cnt = 0;
    logic [31:0] bq_addr[$];
    logic [3:0]  bq_be[$];
    logic        bq_we[$];
    logic [31:0] bq_wd[$];
    int          bq_cyc[$];

    always @(negedge clk) begin
        if (done)       done_cnt++;
        if (fault)      fault_cnt++;
        if (d0_fault)   d0_fault_cnt++;
        if (d0_mem_req) d0_req_cnt++;
        mem_rdata = $urandom;
        if (mem_req && !reset) begin
            cyc++;
            if (cyc > waits_cfg) begin
                mem_ack   = 1'b1;
                mem_rdata = ram[mem_addr[9:2]];
                if (mem_we)
                    for (int b = 0; b < 4; b++)
                        if (mem_be[b]) ram[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                bq_addr.push_back(mem_addr);
                bq_be.push_back(mem_be);
                bq_we.push_back(mem_we);
                bq_wd.push_back(mem_wdata);
                bq_cyc.push_back(cyc);
                cyc = 0;
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            mem_ack = 1'b0;
            cyc     = 0;
        end
    end

    // Byte-level reference memory mirrors the RAM's 1 KiB window.
    logic [7:0] ref_mem [1024];

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic uns);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) begin
            logic [9:0] bi = 10'(a + 32'(i));
            v = v | (32'(ref_mem[bi]) << (8 * i));
        end
        if (n == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
        if (n == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
        for (int i = 0; i < nbytes(sz); i++) begin
            logic [9:0] bi = 10'(a + 32'(i));
            ref_mem[bi] = wd[8*i +: 8];
        end
    endtask

    // res: 1 done, 2 fault, 0 no response. lat counts cycles from accept to the pulse.
    task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] wd, output int res, output int lat);
        bq_addr.delete(); bq_be.delete(); bq_we.delete(); bq_wd.delete(); bq_cyc.delete();
        tick();
        req_valid = 1'b1; data_r = rd; data_w = wr; data_size = sz;
        unsigned_value = uns; addr = a; wdata = wd;
        tick();
        // scramble inputs after accept: the unit must use its latched copy
        req_valid = 1'b0; data_r = 1'($urandom); data_w = 1'($urandom); data_size = 2'($urandom);
        unsigned_value = 1'($urandom); addr = $urandom; wdata = $urandom;
        res = 0;
        lat = 1;
        for (int i = 0; i < 100 && res == 0; i++) begin
            if (done)       res = 1;
            else if (fault) res = 2;
            else begin tick(); lat++; end
        end
    endtask

    typedef struct {
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] a;
        logic [31:0] w0;
        logic [31:0] w1;
        logic [31:0] exp_rd;
        logic [3:0]  be0;
        int          beats;
        int          waits;
    } ld_vec_t;

    typedef struct {
        logic       rd;
        logic       wr;
        logic [1:0] sz;
        logic [31:0] a;
    } flt_vec_t;

    ld_vec_t  lv[10];
    flt_vec_t fv[4];

    initial begin
        int res, lat, d0f, d0r, dc, fc, exp_lat;
        logic [31:0] prev_rd, last_load;
        logic have_load, found;

        lv[0] = '{2'd2, 1'b0, 32'h0000_0100, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 4'hF, 1, 2};
        lv[1] = '{2'd0, 1'b0, 32'h0000_0103, 32'h80112233, 32'h0, 32'hFFFFFF80, 4'h8, 1, 0};
        lv[2] = '{2'd0, 1'b1, 32'h0000_0103, 32'h80112233, 32'h0, 32'h00000080, 4'h8, 1, 1};
        lv[3] = '{2'd2, 1'b0, 32'h0000_01FE, 32'hAABB1234, 32'h5678CCDD, 32'hCCDDAABB, 4'hC, 2, 1};
        lv[4] = '{2'd1, 1'b0, 32'h0000_0102, 32'h80017777, 32'h0, 32'hFFFF8001, 4'hC, 1, 0};
        lv[5] = '{2'd1, 1'b1, 32'h0000_0103, 32'hAB000000, 32'h000000CD, 32'h0000CDAB, 4'h8, 2, 2};
        lv[6] = '{2'd1, 1'b0, 32'h0000_0101, 32'h00F00F00, 32'h0, 32'hFFFFF00F, 4'h6, 1, 0};
        lv[7] = '{2'd0, 1'b0, 32'h0000_0100, 32'h0000007F, 32'h0, 32'h0000007F, 4'h1, 1, 0};
        lv[8] = '{2'd2, 1'b0, 32'hFFFF_FFFF, 32'h11000000, 32'h55443322, 32'h44332211, 4'h8, 2, 0};
        lv[9] = '{2'd2, 1'b1, 32'h0000_0100, 32'h80000000, 32'h0, 32'h80000000, 4'hF, 1, 0};

        fv[0] = '{1'b1, 1'b1, 2'd2, 32'h0000_0100};
        fv[1] = '{1'b1, 1'b0, 2'd3, 32'h0000_0100};
        fv[2] = '{1'b0, 1'b1, 2'd3, 32'h0000_0104};
        fv[3] = '{1'b1, 1'b1, 2'd0, 32'h0000_0101};

        for (int i = 0; i < 256; i++) ram[i] = 32'h0;

        // Reset state
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);

        // Table-driven loads
        for (int i = 0; i < 10; i++) begin
            ram[lv[i].a[9:2]]           = lv[i].w0;
            ram[8'(lv[i].a[9:2] + 8'd1)] = lv[i].w1;
            waits_cfg = lv[i].waits;
            d0f = d0_fault_cnt; d0r = d0_req_cnt;
            run_req(1'b1, 1'b0, lv[i].sz, lv[i].uns, lv[i].a, 32'h0, res, lat);
            exp_lat = 2 + lv[i].waits + ((lv[i].beats == 2) ? 1 + lv[i].waits : 0);
            chk($sformatf("ld%0d_done", i), 32'(res), 32'd1);
            chk($sformatf("ld%0d_rdata", i), rdata, lv[i].exp_rd);
            chk($sformatf("ld%0d_beats", i), 32'(bq_addr.size()), 32'(lv[i].beats));
            chk($sformatf("ld%0d_latency", i), 32'(lat), 32'(exp_lat));
            if (bq_addr.size() >= 1) begin
                chk($sformatf("ld%0d_addr0", i), bq_addr[0], {lv[i].a[31:2], 2'b00});
                chk($sformatf("ld%0d_be0", i), 32'(bq_be[0]), 32'(lv[i].be0));
                chk($sformatf("ld%0d_we0", i), 32'(bq_we[0]), 32'd0);
                chk($sformatf("ld%0d_held", i), 32'(bq_cyc[0]), 32'(lv[i].waits + 1));
            end
            if (lv[i].beats == 2 && bq_addr.size() == 2)
                chk($sformatf("ld%0d_addr1", i), bq_addr[1], {lv[i].a[31:2], 2'b00} + 32'd4);
            if (lv[i].beats == 2) begin
                chk($sformatf("ld%0d_nomis_fault", i), 32'(d0_fault_cnt - d0f), 32'd1);
                chk($sformatf("ld%0d_nomis_req", i), 32'(d0_req_cnt - d0r), 32'd0);
            end else begin
                chk($sformatf("ld%0d_nomis_nofault", i), 32'(d0_fault_cnt - d0f), 32'd0);
            end
            tick();
            chk($sformatf("ld%0d_done_1cyc", i), 32'(done), 32'd0);
        end

        // Misaligned halfword store split across two words
        waits_cfg = 0;
        prev_rd = 32'hDEADBEEF;  // last table load was rdata=0x80000000? no: use table value
        prev_rd = lv[9].exp_rd;
        dc = done_cnt;
        run_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h0000_0203, 32'h0000_1234, res, lat);
        chk("sh_done", 32'(res), 32'd1);
        chk("sh_beats", 32'(bq_addr.size()), 32'd2);
        if (bq_addr.size() == 2) begin
            chk("sh_addr0", bq_addr[0], 32'h200);
            chk("sh_be0", 32'(bq_be[0]), 32'h8);
            chk("sh_wd0", 32'(bq_wd[0][31:24]), 32'h34);
            chk("sh_we0", 32'(bq_we[0]), 32'd1);
            chk("sh_addr1", bq_addr[1], 32'h204);
            chk("sh_be1", 32'(bq_be[1]), 32'h1);
            chk("sh_wd1", 32'(bq_wd[1][7:0]), 32'h12);
            chk("sh_we1", 32'(bq_we[1]), 32'd1);
        end
        repeat (3) tick();
        chk("sh_one_done", 32'(done_cnt - dc), 32'd1);
        chk("sh_rdata_kept", rdata, prev_rd);

        // Illegal requests
        for (int i = 0; i < 4; i++) begin
            run_req(fv[i].rd, fv[i].wr, fv[i].sz, 1'b0, fv[i].a, 32'h55, res, lat);
            chk($sformatf("flt%0d_fault", i), 32'(res), 32'd2);
            chk($sformatf("flt%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("flt%0d_busy", i), 32'(busy), 32'd0);
            chk($sformatf("flt%0d_nobeat", i), 32'(bq_addr.size()), 32'd0);
            tick();
            chk($sformatf("flt%0d_1cyc", i), 32'(fault), 32'd0);
        end

        // Neither data_r nor data_w: ignored
        bq_addr.delete();
        dc = done_cnt; fc = fault_cnt;
        tick();
        req_valid = 1'b1; data_r = 1'b0; data_w = 1'b0; data_size = 2'd2; addr = 32'h100;
        tick();
        req_valid = 1'b0;
        repeat (3) tick();
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_done", 32'(done_cnt - dc), 32'd0);
        chk("nop_fault", 32'(fault_cnt - fc), 32'd0);
        chk("nop_beats", 32'(bq_addr.size()), 32'd0);

        // Reset while the second beat waits for ack
        waits_cfg = 6;
        dc = done_cnt;
        tick();
        req_valid = 1'b1; data_r = 1'b1; data_w = 1'b0; data_size = 2'd2; addr = 32'h1FE;
        tick();
        req_valid = 1'b0; data_r = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_req && mem_addr == 32'h200) found = 1'b1;
            else tick();
        end
        chk("mid_rst_reach_beat1", 32'(found), 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        chk("mid_rst_no_done", 32'(done_cnt - dc), 32'd0);
        waits_cfg = 1;
        ram[8'h40] = 32'h0BAD_F00D;
        run_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, res, lat);
        chk("post_rst_done", 32'(res), 32'd1);
        chk("post_rst_rdata", rdata, 32'h0BAD_F00D);

        // Randomized traffic against the byte-level reference
        for (int i = 0; i < 256; i++) begin
            ram[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_mem[i*4 + b] = ram[i][8*b +: 8];
        end
        have_load = 1'b0;
        last_load = 32'h0;
        for (int n = 0; n < 200; n++) begin
            logic        rd, uns;
            logic [1:0]  sz;
            logic [31:0] a, wd;
            int          nb, off, exp_beats;
            rd  = 1'($urandom);
            uns = 1'($urandom);
            sz  = 2'($urandom_range(0, 2));
            a   = $urandom;
            wd  = $urandom;
            waits_cfg = $urandom_range(0, 2);
            nb  = nbytes(sz);
            off = int'(a[1:0]);
            exp_beats = (off + nb > 4) ? 2 : 1;
            run_req(rd, !rd, sz, uns, a, wd, res, lat);
            chk($sformatf("rnd%0d_done", n), 32'(res), 32'd1);
            chk($sformatf("rnd%0d_beats", n), 32'(bq_addr.size()), 32'(exp_beats));
            chk($sformatf("rnd%0d_lat", n), 32'(lat),
                32'(2 + waits_cfg + ((exp_beats == 2) ? 1 + waits_cfg : 0)));
            if (rd) begin
                last_load = ref_load(a, sz, uns);
                have_load = 1'b1;
                chk($sformatf("rnd%0d_rdata", n), rdata, last_load);
            end else begin
                ref_store(a, sz, wd);
                if (have_load) chk($sformatf("rnd%0d_rdata_kept", n), rdata, last_load);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
